rtc_match_intr: RTL and testbench
=================================

Name: rtc_match_intr

Overview:
- Sits directly downstream of the RTC update stage. Consumes the registered RtcValue and the offset-corrected MatchData, both in the PCLK domain.
- Detects the cycle on which the RTC value steps onto the match value, and holds a sticky raw interrupt status.
- Applies the interrupt mask and drives the RTC interrupt output.
- Also holds the IMSC mask register and handles ICR clear writes decoded by the register block.

Parameters:
- None. All datapaths are fixed at 32 bits, matching the update stage.

Ports:
PCLK  input  1  APB clock; all state on rising edge
PRESETn  input  1  asynchronous active-low reset
RtcValue  input  32  current RTC value from update stage
MatchData  input  32  equivalent match value from update stage
RTCEn  input  1  RTC enable; 0 suppresses match detection
WrenRTCIMSC  input  1  one-cycle write strobe for mask register
WrenRTCICR  input  1  one-cycle write strobe for interrupt clear
PWDATA  input  32  APB write data; bit 0 used (bit 1 under macro)
RTCIMSC  output  1  interrupt mask (1 = enabled)
RTCRIS  output  1  raw (sticky) interrupt status
RTCMIS  output  1  masked status, RTCRIS & RTCIMSC
RTCINTR  output  1  interrupt to system, registered copy of RTCMIS

Behaviour:
- Reset: the async PRESETn low forces RTCIMSC=0, RTCRIS=0, RTCINTR=0, PrevValue=0, MatchHit=0, Armed=0.
- Armed: sets to 1 on the first clock after reset release, then stays 1.
- Stage 0 (combinational), Step = Armed & (RtcValue != PrevValue).
  - PrevValue <= RtcValue on every clock.
- Stage 1:
  - MatchHit <= Step & RTCEn & (RtcValue == MatchData).
  - MatchHit is a single-cycle pulse per value step. A held equal value never re-fires.
- Stage 2, RTCRIS next-state priority:
  - If MatchHit is 1, RTCRIS <= 1. Set wins over a simultaneous clear.
  - Else if WrenRTCICR & PWDATA[0], RTCRIS <= 0.
  - Else RTCRIS holds.
- Latency: if RtcValue steps to the match value at edge N, MatchHit is high after edge N+1, RTCRIS after edge N+2, and RTCINTR after edge N+3 (when masked in).
- RTCIMSC: loads PWDATA[0] on WrenRTCIMSC, otherwise holds.
- RTCMIS: combinational RTCRIS & RTCIMSC.
- RTCINTR <= RTCMIS each clock. Because the output is registered, it is glitch-free.
- MatchData changes: a write that makes MatchData equal the current RtcValue without a value step generates no interrupt. Only a value step matches.
- RtcValue forced to 0 by the update stage (RTCEn low): that step is suppressed by RTCEn=0. Re-enable steps are compared normally.
- Wrap: a step from 0xFFFFFFFF to 0x00000000 is a normal step. It matches when MatchData=0.
- Masked matches: RTCRIS sets even while RTCIMSC=0. Later setting the mask asserts RTCINTR one cycle after the mask write.
- Reset mid-pipeline: any in-flight MatchHit is discarded. Armed=0 blocks a false step on the first post-reset compare.
- ICR writes with PWDATA[0]=0 have no effect. Simultaneous IMSC and ICR strobes are both honoured.

Optional Feature:
- Macro: RTC_MATCH_CNT_EN.
- When defined, add output MatchCount [7:0]: a saturating count of MatchHit pulses.
  - Increments on each MatchHit and holds at 0xFF.
  - Cleared by WrenRTCICR & PWDATA[1]. Clear and increment together give 0x01.
  - Reset value is 0x00.
- When undefined, the port and counter are absent. PWDATA[1] is ignored. All other behaviour is identical.

Test Plan:
- Reset release, then RTCEn=1, MatchData=0x00000005, RtcValue steps 3->4->5 -> RTCRIS=1 exactly 2 clocks after RtcValue=5. With IMSC=1, RTCINTR=1 one clock later.
- RtcValue held at 0x10, then MatchData written to 0x10 -> RTCRIS stays 0. Next step 0x10->0x11 also gives no interrupt.
- IMSC=0, match at 0x20 -> RTCRIS=1, RTCMIS=0, RTCINTR=0. Write IMSC=1 -> RTCMIS=1 immediately, RTCINTR=1 next clock. ICR write 0x1 -> all three 0.
- ICR write 0x1 on the same clock MatchHit=1 -> RTCRIS=1 (set wins). A second ICR write clears it.
- MatchData=0x00000000, RtcValue steps 0xFFFFFFFF->0x00000000 -> RTCRIS=1. The same sequence with RTCEn=0 -> RTCRIS stays 0.
- RTC_MATCH_CNT_EN defined: 300 match events -> MatchCount=0xFF. ICR write 0x2 -> 0x00. ICR 0x2 coinciding with MatchHit -> 0x01.

Source files
------------

// File: rtl/rtc_match_intr.sv
// RTC match interrupt: value-step match detect, sticky raw status, mask and registered IRQ.
// Optional RTC_MATCH_CNT_EN adds a saturating MatchCount of match pulses.
module rtc_match_intr (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] RtcValue,
    input  logic [31:0] MatchData,
    input  logic        RTCEn,
    input  logic        WrenRTCIMSC,
    input  logic        WrenRTCICR,
    input  logic [31:0] PWDATA,
`ifdef RTC_MATCH_CNT_EN
    output logic [7:0]  MatchCount,
`endif
    output logic        RTCIMSC,
    output logic        RTCRIS,
    output logic        RTCMIS,
    output logic        RTCINTR
);

    logic [31:0] PrevValue;
    logic        Armed;
    logic        MatchHit;
    logic        Step;
    logic        unusedPwdata;

    // Armed keeps the reset value of PrevValue from faking a step.
    assign Step   = Armed & (RtcValue != PrevValue);
    assign RTCMIS = RTCRIS & RTCIMSC;

`ifdef RTC_MATCH_CNT_EN
    assign unusedPwdata = ^PWDATA[31:2];
`else
    assign unusedPwdata = ^PWDATA[31:1];
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            Armed     <= 1'b0;
            PrevValue <= '0;
            MatchHit  <= 1'b0;
            RTCRIS    <= 1'b0;
            RTCIMSC   <= 1'b0;
            RTCINTR   <= 1'b0;
        end else begin
            Armed     <= 1'b1;
            PrevValue <= RtcValue;
            MatchHit  <= Step & RTCEn & (RtcValue == MatchData);
            if (MatchHit)
                RTCRIS <= 1'b1;
            else if (WrenRTCICR & PWDATA[0])
                RTCRIS <= 1'b0;
            if (WrenRTCIMSC)
                RTCIMSC <= PWDATA[0];
            RTCINTR   <= RTCMIS;
        end
    end

`ifdef RTC_MATCH_CNT_EN
    logic cntClr;
    assign cntClr = WrenRTCICR & PWDATA[1];

    // A clear coinciding with a hit still counts that hit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            MatchCount <= 8'h00;
        else if (cntClr)
            MatchCount <= MatchHit ? 8'h01 : 8'h00;
        else if (MatchHit && MatchCount != 8'hFF)
            MatchCount <= MatchCount + 8'h01;
    end
`endif

endmodule

// File: tb/tb_rtc_match_intr.sv
// Scoreboard bench for rtc_match_intr: directed steps, expectations queued per cycle.
// Vector order checked: {RTCIMSC, RTCRIS, RTCMIS, RTCINTR}.
module tb_rtc_match_intr;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] RtcValue;
    logic [31:0] MatchData;
    logic        RTCEn;
    logic        WrenRTCIMSC;
    logic        WrenRTCICR;
    logic [31:0] PWDATA;
    logic        RTCIMSC;
    logic        RTCRIS;
    logic        RTCMIS;
    logic        RTCINTR;
`ifdef RTC_MATCH_CNT_EN
    logic [7:0]  MatchCount;
`endif

    rtc_match_intr dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .RtcValue    (RtcValue),
        .MatchData   (MatchData),
        .RTCEn       (RTCEn),
        .WrenRTCIMSC (WrenRTCIMSC),
        .WrenRTCICR  (WrenRTCICR),
        .PWDATA      (PWDATA),
`ifdef RTC_MATCH_CNT_EN
        .MatchCount  (MatchCount),
`endif
        .RTCIMSC     (RTCIMSC),
        .RTCRIS      (RTCRIS),
        .RTCMIS      (RTCMIS),
        .RTCINTR     (RTCINTR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int         due;
        string      tag;
        bit         chkCnt;
        logic [3:0] vec;
        logic [7:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic expVec(input int d, input string t, input logic [3:0] v);
        exp_t e;
        e.due = cyc + d; e.tag = t; e.chkCnt = 1'b0; e.vec = v; e.cnt = 8'h00;
        expQ.push_back(e);
    endtask

    task automatic expCnt(input int d, input string t, input logic [7:0] c);
        exp_t e;
        e.due = cyc + d; e.tag = t; e.chkCnt = 1'b1; e.vec = 4'h0; e.cnt = c;
        expQ.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge PCLK) begin
        logic [3:0] act;
        act = {RTCIMSC, RTCRIS, RTCMIS, RTCINTR};
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].due == cyc) begin
                checks = checks + 1;
                if (expQ[i].chkCnt) begin
`ifdef RTC_MATCH_CNT_EN
                    if (MatchCount !== expQ[i].cnt) begin
                        errors = errors + 1;
                        $display("FAIL %s: MatchCount got %h want %h",
                                 expQ[i].tag, MatchCount, expQ[i].cnt);
                    end
`endif
                end else if (act !== expQ[i].vec) begin
                    errors = errors + 1;
                    $display("FAIL %s: imsc/ris/mis/intr got %b want %b",
                             expQ[i].tag, act, expQ[i].vec);
                end
                expQ.delete(i);
            end else if (expQ[i].due < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s: missed check got none want due %0d",
                         expQ[i].tag, expQ[i].due);
                expQ.delete(i);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; RtcValue = '0; MatchData = '0; RTCEn = 1'b0;
        WrenRTCIMSC = 1'b0; WrenRTCICR = 1'b0; PWDATA = '0;
        tick();
        expVec(0, "reset", 4'b0000);
`ifdef RTC_MATCH_CNT_EN
        expCnt(0, "reset_cnt", 8'h00);
`endif
        tick();
        PRESETn = 1'b1;
        tick();

        // Basic match 3->4->5 with mask enabled
        RTCEn = 1'b1; MatchData = 32'h5; RtcValue = 32'h3;
        WrenRTCIMSC = 1'b1; PWDATA = 32'h1;
        tick();
        WrenRTCIMSC = 1'b0; RtcValue = 32'h4;
        tick();
        RtcValue = 32'h5;
        expVec(1, "t1_hit_stage", 4'b1000);
        expVec(2, "t1_ris", 4'b1110);
        expVec(3, "t1_intr", 4'b1111);
        tick(); tick(); tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h1;
        expVec(1, "t1_icr", 4'b1001);
        expVec(2, "t1_icr_intr", 4'b1000);
        tick();
        WrenRTCICR = 1'b0;
        tick();

        // Match value written onto a held value: no interrupt
        RtcValue = 32'h10;
        tick(); tick();
        MatchData = 32'h10;
        expVec(1, "t2_hold_a", 4'b1000);
        expVec(3, "t2_hold_b", 4'b1000);
        tick(); tick(); tick();
        RtcValue = 32'h11;
        expVec(2, "t2_step_away", 4'b1000);
        expVec(3, "t2_step_away2", 4'b1000);
        tick(); tick(); tick();

        // Masked match, then unmask, then clear
        WrenRTCIMSC = 1'b1; PWDATA = 32'h0;
        tick();
        WrenRTCIMSC = 1'b0;
        MatchData = 32'h20; RtcValue = 32'h20;
        expVec(2, "t3_masked_ris", 4'b0100);
        expVec(3, "t3_masked_hold", 4'b0100);
        tick(); tick(); tick();
        WrenRTCIMSC = 1'b1; PWDATA = 32'h1;
        expVec(1, "t3_unmask_mis", 4'b1110);
        expVec(2, "t3_unmask_intr", 4'b1111);
        tick();
        WrenRTCIMSC = 1'b0;
        tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h0;
        expVec(1, "t3_icr_zero", 4'b1111);
        tick();
        PWDATA = 32'h1;
        expVec(1, "t3_icr_clr", 4'b1001);
        expVec(2, "t3_icr_intr", 4'b1000);
        tick();
        WrenRTCICR = 1'b0;
        tick();

        // Set wins over a simultaneous clear
        RtcValue = 32'h21; MatchData = 32'h21;
        tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h1;
        expVec(1, "t4_set_wins", 4'b1110);
        tick();
        WrenRTCICR = 1'b0;
        expVec(1, "t4_set_intr", 4'b1111);
        tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h1;
        expVec(1, "t4_second_clr", 4'b1001);
        expVec(2, "t4_second_intr", 4'b1000);
        tick();
        WrenRTCICR = 1'b0;
        tick();

        // Wrap step matches MatchData=0
        MatchData = 32'h0; RtcValue = 32'hFFFF_FFFF;
        tick(); tick();
        RtcValue = 32'h0;
        expVec(2, "t5_wrap_ris", 4'b1110);
        expVec(3, "t5_wrap_intr", 4'b1111);
        tick(); tick(); tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h1;
        tick();
        WrenRTCICR = 1'b0;
        tick();
        RTCEn = 1'b0; RtcValue = 32'hFFFF_FFFF;
        tick(); tick();
        RtcValue = 32'h0;
        expVec(2, "t5_disabled", 4'b1000);
        expVec(3, "t5_disabled2", 4'b1000);
        tick(); tick(); tick();

        // Reset with a match in flight, value held equal across release
        RTCEn = 1'b1; RtcValue = 32'h40; MatchData = 32'h40;
        tick();
        PRESETn = 1'b0;
        #1;
        expVec(0, "t6_rst_async", 4'b0000);
        tick();
        PRESETn = 1'b1;
        expVec(1, "t6_post_a", 4'b0000);
        expVec(2, "t6_post_b", 4'b0000);
        expVec(3, "t6_post_c", 4'b0000);
        tick(); tick(); tick();

`ifdef RTC_MATCH_CNT_EN
        for (int i = 0; i < 300; i++) begin
            RtcValue = 32'h100 + i; MatchData = 32'h100 + i;
            tick();
        end
        tick(); tick();
        expCnt(0, "t7_saturate", 8'hFF);
        WrenRTCICR = 1'b1; PWDATA = 32'h2;
        expCnt(1, "t7_clear", 8'h00);
        expVec(1, "t7_clear_ris_kept", 4'b0100);
        tick();
        WrenRTCICR = 1'b0;
        tick();
        RtcValue = 32'h500; MatchData = 32'h500;
        tick();
        WrenRTCICR = 1'b1; PWDATA = 32'h2;
        expCnt(1, "t7_clr_and_inc", 8'h01);
        tick();
        WrenRTCICR = 1'b0;
        tick();
`endif

        tick(); tick(); tick();
        if (expQ.size() != 0) begin
            checks = checks + expQ.size();
            errors = errors + expQ.size();
            $display("FAIL drain: pending got %0d want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
